// File: rtl/store_monitor.sv
// store_monitor: store-bus verdict monitor with a store log; define STORE_MONITOR_X_CHECK_EN to fail on X/Z store inputs
module store_monitor #(
    parameter logic [31:0] PASS_ADDR      = 32'd100,
    parameter logic [31:0] PASS_DATA      = 32'd25,
    parameter int          TIMEOUT_CYCLES = 10000,
    parameter int          LOG_DEPTH      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic        log_rd,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [15:0] store_count,
    output logic [31:0] cycle_count,
    output logic        log_valid,
    output logic [31:0] log_addr,
    output logic [31:0] log_data,
    output logic        log_overflow
);
    localparam int AW = $clog2(LOG_DEPTH);

    typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

    state_t        state, state_n;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ;
    logic [31:0]   mem_addr [LOG_DEPTH];
    logic [31:0]   mem_data [LOG_DEPTH];
    logic          run, x_bad, store, terminal, full, pop, push_ok;

    assign run = state == S_RUN;
`ifdef STORE_MONITOR_X_CHECK_EN
    assign x_bad = run && ($isunknown(MemWrite) ||
                   (MemWrite === 1'b1 && ($isunknown(DataAdr) || $isunknown(WriteData))));
`else
    assign x_bad = 1'b0;
`endif
    assign store    = run && MemWrite && !x_bad;
    assign terminal = store && DataAdr == PASS_ADDR;
    assign full     = occ == (AW+1)'(LOG_DEPTH);
    assign pop      = log_rd && occ != '0;
    assign push_ok  = store && (!full || pop);

    assign done      = !run;
    assign pass      = state == S_PASS;
    assign fail      = state == S_FAIL;
    assign timeout   = state == S_TIMEOUT;
    assign log_valid = occ != '0;
    assign log_addr  = log_valid ? mem_addr[rd_ptr] : '0;
    assign log_data  = log_valid ? mem_data[rd_ptr] : '0;

    // Verdict: X fault, then terminal store, then timeout; terminal states hold
    always_comb begin
        state_n = state;
        if (run)
            state_n = x_bad    ? S_FAIL :
                      terminal ? (WriteData == PASS_DATA ? S_PASS : S_FAIL) :
                      cycle_count == 32'(TIMEOUT_CYCLES - 1) ? S_TIMEOUT : S_RUN;
    end

    // State, counters and log pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_RUN;
            cycle_count  <= '0;
            store_count  <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            log_overflow <= 1'b0;
        end else begin
            state <= state_n;
            if (run)
                cycle_count <= cycle_count + 32'd1;
            if (store && store_count != 16'hFFFF)
                store_count <= store_count + 16'd1;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            occ <= occ + (AW+1)'(push_ok) - (AW+1)'(pop);
            if (store && full && !pop)
                log_overflow <= 1'b1;
        end
    end

    // Log storage; contents are masked by log_valid so no reset is needed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_addr[wr_ptr] <= DataAdr;
            mem_data[wr_ptr] <= WriteData;
        end
    end

`ifdef STORE_MONITOR_X_CHECK_EN
    // Report unknown store inputs that forced the FAIL verdict
    always @(posedge clk) begin
        if (!reset && x_bad)
            $error("store_monitor: unknown store input MemWrite=%b DataAdr=%h WriteData=%h",
                   MemWrite, DataAdr, WriteData);
    end
`endif
endmodule

// File: tb/tb_store_monitor.sv
// tb_store_monitor: directed and random checks of store_monitor against a queue-based model
module tb_store_monitor;
    localparam int TO    = 50;
    localparam int DEPTH = 8;

    logic        clk = 1'b0, reset = 1'b1, MemWrite = 1'b0, log_rd = 1'b0;
    logic [31:0] DataAdr = '0, WriteData = '0;
    logic        done, pass, fail, timeout, log_valid, log_overflow;
    logic [15:0] store_count;
    logic [31:0] cycle_count, log_addr, log_data;

    int checks = 0, errors = 0;

    // model: 0 running, 1 pass, 2 fail, 3 timeout
    int          m_verdict, m_cycles, m_stores;
    bit          m_ovf;
    logic [63:0] m_q [$];

    store_monitor #(.TIMEOUT_CYCLES(TO), .LOG_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .log_rd(log_rd), .done(done), .pass(pass),
        .fail(fail), .timeout(timeout), .store_count(store_count),
        .cycle_count(cycle_count), .log_valid(log_valid), .log_addr(log_addr),
        .log_data(log_data), .log_overflow(log_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [63:0] head;
        head = m_q.size() > 0 ? m_q[0] : 64'd0;
        chk({tag, "/done"},    32'(done),         32'(m_verdict != 0));
        chk({tag, "/pass"},    32'(pass),         32'(m_verdict == 1));
        chk({tag, "/fail"},    32'(fail),         32'(m_verdict == 2));
        chk({tag, "/timeout"}, 32'(timeout),      32'(m_verdict == 3));
        chk({tag, "/stores"},  32'(store_count),  32'(m_stores));
        chk({tag, "/cycles"},  cycle_count,       32'(m_cycles));
        chk({tag, "/valid"},   32'(log_valid),    32'(m_q.size() > 0));
        chk({tag, "/addr"},    log_addr,          head[63:32]);
        chk({tag, "/data"},    log_data,          head[31:0]);
        chk({tag, "/ovf"},     32'(log_overflow), 32'(m_ovf));
    endtask

    task automatic model_reset();
        m_verdict = 0;
        m_cycles  = 0;
        m_stores  = 0;
        m_ovf     = 1'b0;
        m_q.delete();
    endtask

    task automatic step(input string tag, input logic mw, input logic [31:0] a,
                        input logic [31:0] d, input logic rd);
        MemWrite  = mw;
        DataAdr   = a;
        WriteData = d;
        log_rd    = rd;
        if (rd && m_q.size() > 0)
            void'(m_q.pop_front());
        if (m_verdict == 0) begin
            if (mw) begin
                if (m_stores < 65535)
                    m_stores++;
                if (m_q.size() < DEPTH)
                    m_q.push_back({a, d});
                else
                    m_ovf = 1'b1;
            end
            if (mw && a == 100)
                m_verdict = (d == 25) ? 1 : 2;
            else if (m_cycles == TO - 1)
                m_verdict = 3;
            m_cycles++;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        MemWrite = 1'b0;
        log_rd   = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic        mw, rd;
        logic [31:0] a, d;

        do_reset();
        step("s1", 1, 32'h60, 7, 0);
        step("s2", 1, 32'h64, 9, 0);
        step("pass", 1, 100, 25, 0);
        repeat (4) step("drain", 0, 0, 0, 1);

        do_reset();
        step("wrong", 1, 100, 24, 0);
        step("late", 1, 100, 25, 0);
        repeat (2) step("frozen", 0, 0, 0, 0);

        do_reset();
        repeat (TO) step("idle", 0, 0, 0, 0);
        repeat (2) step("to_hold", 0, 0, 0, 0);

        do_reset();
        repeat (TO - 1) step("idle2", 0, 0, 0, 0);
        step("edge_pass", 1, 100, 25, 0);

        do_reset();
        for (int i = 0; i < 10; i++) step("fill", 1, 32'h200 + 32'(4 * i), 32'(i), 0);
        repeat (9) step("ovf_drain", 0, 0, 0, 1);

        do_reset();
        for (int i = 0; i < 8; i++) step("fill8", 1, 32'h300 + 32'(4 * i), 32'(i), 0);
        for (int i = 0; i < 4; i++) step("full_pp", 1, 32'h400 + 32'(4 * i), 32'(i), 1);
        repeat (9) step("pp_drain", 0, 0, 0, 1);

        do_reset();
        step("empty_pp", 1, 32'h10, 1, 1);
        step("m1", 1, 32'h20, 2, 0);
        step("m2", 1, 32'h24, 3, 0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("async");
        #2;
        reset = 1'b0;
        step("after_async", 1, 100, 25, 0);

        for (int r = 0; r < 6; r++) begin
            do_reset();
            repeat (45) begin
                mw = 1'($urandom_range(0, 1));
                a  = ($urandom_range(0, 19) == 0) ? 32'd100 : 32'($urandom_range(0, 255)) << 2;
                d  = (a == 100) ? 32'($urandom_range(24, 26)) : $urandom;
                rd = ($urandom_range(0, 2) == 0);
                step("rand", mw, a, d, rd);
            end
        end

`ifdef STORE_MONITOR_X_CHECK_EN
        do_reset();
        MemWrite  = 1'b1;
        DataAdr   = 32'h80;
        WriteData = 32'hxxxx_0000;
        @(posedge clk);
        #1;
        chk("x/fail", 32'(fail), 32'd1);
        chk("x/stores", 32'(store_count), 32'd0);
        chk("x/valid", 32'(log_valid), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/store_monitor.md
# store_monitor

Self-checking store monitor on the data-memory write port of the pipelined core's top level. Each clock it samples the memory-stage store signals `MemWrite`, `DataAdr` and `WriteData`. It logs every store into a small FIFO and counts stores and cycles. It ends the run with a sticky PASS, FAIL or TIMEOUT verdict, so benches and FPGA wrappers read one status instead of decoding the bus themselves.

## Interface
- `PASS_ADDR`, default 32'd100: address of the terminal (verdict) store.
- `PASS_DATA`, default 32'd25: data value at `PASS_ADDR` that means PASS.
- `TIMEOUT_CYCLES`, default 10000: number of RUN cycles allowed before TIMEOUT; minimum 2.
- `LOG_DEPTH`, default 8: number of store-log FIFO entries; power of two, minimum 2.
- `clk` in 1: rising-edge clock, shared with the core.
- `reset` in 1: asynchronous, active-high reset.
- `MemWrite` in 1: store strobe from the core.
- `DataAdr` in 32: store address.
- `WriteData` in 32: store data.
- `log_rd` in 1: pops the log head.
- `done` out 1: a verdict has been reached.
- `pass` out 1: verdict is PASS.
- `fail` out 1: verdict is FAIL.
- `timeout` out 1: verdict is TIMEOUT.
- `store_count` out 16: stores sampled in RUN.
- `cycle_count` out 32: cycles spent in RUN.
- `log_valid` out 1: log FIFO is non-empty.
- `log_addr` out 32: address of the head log entry.
- `log_data` out 32: data of the head log entry.
- `log_overflow` out 1: a store was dropped because the log was full.

## Operation
- FSM states: RUN, PASS, FAIL, TIMEOUT. Reset enters RUN. PASS, FAIL and TIMEOUT are terminal and sticky until `reset`.
- RUN, `MemWrite`=1 and `DataAdr`==`PASS_ADDR`:
  - `WriteData`==`PASS_DATA` → PASS.
  - any other data → FAIL.
- RUN, `MemWrite`=1 at any other address: count the store, log it, stay in RUN.
- RUN, no terminal store, `cycle_count`==`TIMEOUT_CYCLES`-1 → TIMEOUT.
- Terminal store and timeout condition on the same edge: the store verdict (PASS or FAIL) wins.
- `store_count`: increments on every store sampled in RUN, including the terminal store. Saturates at 16'hFFFF.
- `cycle_count`: increments every RUN cycle, including the cycle that transitions out of RUN. Frozen in terminal states.
- Log FIFO:
  - Push: every store sampled in RUN, including the terminal store. No pushes in terminal states.
  - Read: first-word-fall-through; `log_addr` and `log_data` show the head whenever `log_valid`=1.
  - Pop: `log_rd`=1 with `log_valid`=1 pops on that edge. `log_rd` while empty is ignored.
  - Full with push and no pop: the new entry is dropped and `log_overflow` sets (sticky until reset).
  - Full with simultaneous push and pop: both happen, no drop.
  - Empty with simultaneous push and pop: the pop is ignored and the push is kept.
  - Pointers wrap modulo `LOG_DEPTH`. Occupancy uses one extra bit so full and empty are distinguishable.
- Popping continues in terminal states so the log can be drained after the verdict.

## Timing
- Reset values (asynchronous): state RUN; `done`, `pass`, `fail`, `timeout`, `log_valid`, `log_overflow` all 0; `store_count`=0; `cycle_count`=0; `log_addr`=0; `log_data`=0; FIFO empty.
- All outputs are registered, or are direct reads of FIFO storage selected by a registered pointer. No combinational path from inputs to outputs.
- A store sampled at edge N is visible as follows from edge N onward:
  - Verdict flags (`done` together with exactly one of `pass`/`fail`/`timeout`).
  - `store_count`.
  - `log_valid`, if the FIFO was empty.
- Timeout: `timeout` rises at edge `TIMEOUT_CYCLES`, counting edges after reset deassertion. `cycle_count` then reads `TIMEOUT_CYCLES`.
- Reset asserted mid-run clears everything immediately without waiting for `clk`. The first sampled edge after deassertion is RUN cycle 0.

## Configuration
- `STORE_MONITOR_X_CHECK_EN` defined:
  - In RUN, `MemWrite` being X/Z forces FAIL and issues `$error`.
  - In RUN, `MemWrite`=1 with any X/Z bit in `DataAdr` or `WriteData` forces FAIL and issues `$error`.
  - Such a cycle is neither counted nor logged.
- Macro undefined: no X checks; X inputs propagate per normal 4-state semantics. Synthesisable.

## Test plan
- Reset → stores: reset, then stores (0x60,7), (0x64,9), then (100,25) → `pass`=1, `done`=1, `store_count`=3, log pops in order (0x60,7), (0x64,9), (100,25).
- Wrong verdict data: store (100,24) → `fail`=1, `pass`=0. A later store (100,25) changes nothing; `store_count` stays frozen.
- Timeout: `TIMEOUT_CYCLES`=50, no stores → `timeout`=1 at edge 50 and `cycle_count`=50. A variant places (100,25) exactly on edge 50 → `pass`=1, `timeout`=0.
- Log overflow: `LOG_DEPTH`=8, ten non-terminal stores with no pops → `log_overflow`=1, 8 entries pop (first eight stores), then `log_valid`=0. A variant pops every cycle while the log is full → no overflow.
- Mid-run reset: async `reset` pulse between clock edges after 3 stores → all outputs are 0 immediately. A subsequent (100,25) store → `pass`=1, `store_count`=1.
- With `STORE_MONITOR_X_CHECK_EN`: `MemWrite`=1 and `WriteData`=32'hxxxx_0000 → `fail`=1, `$error` logged, `store_count`=0.
